rv32i_issue_ctrl: RTL and testbench

//  Issue controller between decode-field extraction and execute. Holds one decoded

---
 rtl/rv32i_package.sv | 34 +++
 rtl/rv32i_scoreboard.sv | 65 ++++++
 rtl/rv32i_issue_ctrl.sv | 139 +++++++++++++
 tb/tb_rv32i_issue_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_package.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv32i_package : shared opcode constants, register/state types.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package rv32i_package;

  localparam logic [4:0] OP_LOAD     = 5'b00000;
  localparam logic [4:0] OP_MISC_MEM = 5'b00011;
  localparam logic [4:0] OP_OP_IMM   = 5'b00100;
  localparam logic [4:0] OP_AUIPC    = 5'b00101;
  localparam logic [4:0] OP_STORE    = 5'b01000;
  localparam logic [4:0] OP_OP       = 5'b01100;
  localparam logic [4:0] OP_LUI      = 5'b01101;
  localparam logic [4:0] OP_BRANCH   = 5'b11000;
  localparam logic [4:0] OP_JALR     = 5'b11001;
  localparam logic [4:0] OP_JAL      = 5'b11011;
  localparam logic [4:0] OP_SYSTEM   = 5'b11100;

  typedef logic [4:0] reg_addr_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } issue_state_t;

  // x0 maps to an empty mask so it can never become busy or hazard.
  function automatic logic [31:0] reg_onehot(input reg_addr_t a);
    return (a == 5'd0) ? 32'd0 : (32'd1 << a);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv32i_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv32i_scoreboard : busy bits, in-flight counter, sticky wb error and     |
// | the combinational hazard lookup. Rev 1.0                                 |
// +--------------------------------------------------------------------------+
module rv32i_scoreboard
  import rv32i_package::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_fire,
  input  reg_addr_t   issue_rd,
  input  logic        wb_valid,
  input  reg_addr_t   wb_rd,
  input  logic        slot_valid,
  input  reg_addr_t   slot_rd,
  input  reg_addr_t   lk_rs1,
  input  reg_addr_t   lk_rs2,
  input  reg_addr_t   lk_rd,
  output logic        hazard,
  output logic [31:0] busy_mask,
  output logic [3:0]  inflight,
  output logic        wb_err
);

  logic [31:0] busy_q, busy_d;
  logic [3:0]  inflight_q, inflight_d;
  logic        wb_err_q, wb_err_d;

  logic [31:0] set_bit, wb_bit, clr_bit, pending;
  logic        wb_hit;

  always_comb begin
    set_bit    = issue_fire ? reg_onehot(issue_rd) : 32'd0;
    wb_bit     = wb_valid ? reg_onehot(wb_rd) : 32'd0;
    wb_hit     = |(wb_bit & busy_q);
    clr_bit    = wb_hit ? wb_bit : 32'd0;
    // Set is applied after clear so a same-register collision keeps the bit.
    busy_d     = (busy_q & ~clr_bit) | set_bit;
    inflight_d = inflight_q + {3'd0, |set_bit} - {3'd0, wb_hit};
    wb_err_d   = wb_err_q | (wb_valid & ~wb_hit);

    // Writeback bypass: a register retiring this cycle no longer blocks decode.
    pending    = (busy_q | (slot_valid ? reg_onehot(slot_rd) : 32'd0)) & ~wb_bit;
    hazard     = pending[lk_rs1] | pending[lk_rs2] | pending[lk_rd];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q     <= 32'd0;
      inflight_q <= 4'd0;
      wb_err_q   <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign busy_mask = busy_q;
  assign inflight  = inflight_q;
  assign wb_err    = wb_err_q;

endmodule
`default_nettype wire

// File: rtl/rv32i_issue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv32i_issue_ctrl : single-entry issue slot with scoreboard-based stall,  |
// | flush and drain control. Rev 1.0                                         |
// +--------------------------------------------------------------------------+
module rv32i_issue_ctrl
  import rv32i_package::*;
#(
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [4:0]  dec_opcode,
  input  logic [2:0]  dec_funct3,
  input  logic [4:0]  dec_rs1_address,
  input  logic [4:0]  dec_rs2_address,
  input  logic [4:0]  dec_rd_address,
  output logic        iss_valid,
  input  logic        iss_ready,
  output logic [4:0]  iss_opcode,
  output logic [2:0]  iss_funct3,
  output logic [4:0]  iss_rs1_address,
  output logic [4:0]  iss_rs2_address,
  output logic [4:0]  iss_rd_address,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd_address,
  input  logic        flush,
  input  logic        drain_req,
  output logic        drain_done,
  output logic [31:0] busy_mask,
  output logic [3:0]  inflight,
  output logic        wb_err
);

  localparam logic [4:0] C_MAX = 5'(MAX_INFLIGHT);

  issue_state_t state_q, state_d;

  logic       valid_q, valid_d;
  logic [4:0] opcode_q, opcode_d;
  logic [2:0] funct3_q, funct3_d;
  logic [4:0] rs1_q, rs1_d;
  logic [4:0] rs2_q, rs2_d;
  logic [4:0] rd_q, rd_d;

  logic hazard, issue_fire, accept, slot_has_rd;

  rv32i_scoreboard u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .issue_fire (issue_fire),
    .issue_rd   (rd_q),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd_address),
    .slot_valid (valid_q),
    .slot_rd    (rd_q),
    .lk_rs1     (dec_rs1_address),
    .lk_rs2     (dec_rs2_address),
    .lk_rd      (dec_rd_address),
    .hazard     (hazard),
    .busy_mask  (busy_mask),
    .inflight   (inflight),
    .wb_err     (wb_err)
  );

  always_comb begin
    slot_has_rd = valid_q & (rd_q != 5'd0);
    issue_fire  = valid_q & iss_ready & ~flush;
    // The occupied slot counts toward the cap because it will issue next.
    dec_ready   = ~reset & (state_q == RUN) & ~flush & ~hazard
                & (~valid_q | iss_ready)
                & (({1'b0, inflight} + {4'd0, slot_has_rd}) < C_MAX);
    accept      = dec_valid & dec_ready;

    valid_d  = valid_q;
    opcode_d = opcode_q;
    funct3_d = funct3_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      opcode_d = dec_opcode;
      funct3_d = dec_funct3;
      rs1_d    = dec_rs1_address;
      rs2_d    = dec_rs2_address;
      rd_d     = dec_rd_address;
    end else if (iss_ready) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:   if (drain_req) state_d = DRAIN;
      DRAIN: begin
        if (!drain_req)                          state_d = RUN;
        else if (!valid_q && inflight == 4'd0)   state_d = DONE;
      end
      DONE:  if (!drain_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      valid_q  <= 1'b0;
      opcode_q <= 5'd0;
      funct3_q <= 3'd0;
      rs1_q    <= 5'd0;
      rs2_q    <= 5'd0;
      rd_q     <= 5'd0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      opcode_q <= opcode_d;
      funct3_q <= funct3_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
    end
  end

  assign iss_valid       = valid_q;
  assign iss_opcode      = opcode_q;
  assign iss_funct3      = funct3_q;
  assign iss_rs1_address = rs1_q;
  assign iss_rs2_address = rs2_q;
  assign iss_rd_address  = rd_q;
  assign drain_done      = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_rv32i_issue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rv32i_issue_ctrl : directed vectors and corner sequences.             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_rv32i_issue_ctrl;
  import rv32i_package::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid, dec_ready;
  logic [4:0]  dec_opcode;
  logic [2:0]  dec_funct3;
  logic [4:0]  dec_rs1_address, dec_rs2_address, dec_rd_address;
  logic        iss_valid, iss_ready;
  logic [4:0]  iss_opcode;
  logic [2:0]  iss_funct3;
  logic [4:0]  iss_rs1_address, iss_rs2_address, iss_rd_address;
  logic        wb_valid;
  logic [4:0]  wb_rd_address;
  logic        flush, drain_req, drain_done;
  logic [31:0] busy_mask;
  logic [3:0]  inflight;
  logic        wb_err;

  int total = 0;
  int bad   = 0;

  rv32i_issue_ctrl #(.MAX_INFLIGHT(4)) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_opcode(dec_opcode), .dec_funct3(dec_funct3),
    .dec_rs1_address(dec_rs1_address), .dec_rs2_address(dec_rs2_address),
    .dec_rd_address(dec_rd_address),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_opcode(iss_opcode), .iss_funct3(iss_funct3),
    .iss_rs1_address(iss_rs1_address), .iss_rs2_address(iss_rs2_address),
    .iss_rd_address(iss_rd_address),
    .wb_valid(wb_valid), .wb_rd_address(wb_rd_address),
    .flush(flush), .drain_req(drain_req), .drain_done(drain_done),
    .busy_mask(busy_mask), .inflight(inflight), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       dv;
    logic [4:0] op;
    logic [4:0] rs1, rs2, rd;
    logic       ir, wv;
    logic [4:0] wrd;
    logic       e_rdy, e_iv;
    logic [4:0] e_ird;
    logic [31:0] e_busy;
    logic [3:0] e_infl;
    logic       e_err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic dv, input logic [4:0] op, input logic [2:0] f3,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic ir, input logic wv, input logic [4:0] wrd,
                     input logic fl, input logic dr);
    dec_valid = dv; dec_opcode = op; dec_funct3 = f3;
    dec_rs1_address = rs1; dec_rs2_address = rs2; dec_rd_address = rd;
    iss_ready = ir; wb_valid = wv; wb_rd_address = wrd;
    flush = fl; drain_req = dr;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drv(0, 5'd0, 3'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0);
    cyc();
    cyc();
    chk("rst_dec_ready", {31'd0, dec_ready}, 32'd0);
    chk("rst_iss_valid", {31'd0, iss_valid}, 32'd0);
    chk("rst_busy", busy_mask, 32'd0);
    chk("rst_inflight", {28'd0, inflight}, 32'd0);
    chk("rst_err_done", {30'd0, wb_err, drain_done}, 32'd0);
    chk("rst_iss_fields", {12'd0, iss_opcode, iss_funct3, iss_rs1_address,
                           iss_rs2_address, iss_rd_address}, 32'd0);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    // Pipelined RAW/x0/wb_err walk starting from reset.
    vecs[0] = '{1, OP_OP,    5'd1, 5'd2, 5'd5, 1, 0, 5'd0, 1, 1, 5'd5, 32'h0,  4'd0, 0};
    vecs[1] = '{1, OP_OP,    5'd5, 5'd0, 5'd6, 1, 0, 5'd0, 0, 0, 5'd5, 32'h20, 4'd1, 0};
    vecs[2] = '{1, OP_OP,    5'd5, 5'd0, 5'd6, 1, 0, 5'd0, 0, 0, 5'd5, 32'h20, 4'd1, 0};
    vecs[3] = '{1, OP_OP,    5'd5, 5'd0, 5'd6, 1, 1, 5'd5, 1, 1, 5'd6, 32'h0,  4'd0, 0};
    vecs[4] = '{1, OP_STORE, 5'd0, 5'd0, 5'd0, 1, 0, 5'd0, 1, 1, 5'd0, 32'h40, 4'd1, 0};
    vecs[5] = '{0, OP_LOAD,  5'd0, 5'd0, 5'd0, 1, 1, 5'd9, 1, 0, 5'd0, 32'h40, 4'd1, 1};
    vecs[6] = '{0, OP_LOAD,  5'd0, 5'd0, 5'd0, 1, 1, 5'd6, 1, 0, 5'd0, 32'h0,  4'd0, 1};

    do_reset();
    for (int i = 0; i < 7; i++) begin
      drv(vecs[i].dv, vecs[i].op, 3'd0, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
          vecs[i].ir, vecs[i].wv, vecs[i].wrd, 0, 0);
      chk($sformatf("v%0d_dec_ready", i), {31'd0, dec_ready}, {31'd0, vecs[i].e_rdy});
      cyc();
      chk($sformatf("v%0d_iss_valid", i), {31'd0, iss_valid}, {31'd0, vecs[i].e_iv});
      chk($sformatf("v%0d_iss_rd", i), {27'd0, iss_rd_address}, {27'd0, vecs[i].e_ird});
      chk($sformatf("v%0d_busy", i), busy_mask, vecs[i].e_busy);
      chk($sformatf("v%0d_inflight", i), {28'd0, inflight}, {28'd0, vecs[i].e_infl});
      chk($sformatf("v%0d_wb_err", i), {31'd0, wb_err}, {31'd0, vecs[i].e_err});
    end

    // Backpressure: slot must hold while execute stalls.
    do_reset();
    drv(1, OP_LOAD, 3'd2, 5'd1, 5'd0, 5'd3, 0, 0, 5'd0, 0, 0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      drv(1, OP_OP, 3'd0, 5'd2, 5'd2, 5'd4, 0, 0, 5'd0, 0, 0);
      chk("bp_dec_ready", {31'd0, dec_ready}, 32'd0);
      cyc();
      chk("bp_iss_slot", {22'd0, iss_valid, iss_opcode, iss_funct3, iss_rs1_address},
          {22'd0, 1'b1, OP_LOAD, 3'd2, 5'd1});
      chk("bp_iss_rd", {27'd0, iss_rd_address}, 32'd3);
      chk("bp_busy", busy_mask, 32'd0);
    end
    drv(0, OP_OP, 3'd0, 5'd0, 5'd0, 5'd0, 1, 0, 5'd0, 0, 0);
    cyc();
    chk("bp_rel_valid", {31'd0, iss_valid}, 32'd0);
    chk("bp_rel_busy", busy_mask, 32'h8);
    chk("bp_rel_inflight", {28'd0, inflight}, 32'd1);

    // In-flight cap with MAX_INFLIGHT=4.
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drv(1, OP_LOAD, 3'd2, 5'd0, 5'd0, 5'(i), 1, 0, 5'd0, 0, 0);
      chk($sformatf("cap_ready_x%0d", i), {31'd0, dec_ready}, 32'd1);
      cyc();
    end
    drv(1, OP_LOAD, 3'd2, 5'd0, 5'd0, 5'd5, 1, 0, 5'd0, 0, 0);
    chk("cap_block_slot", {31'd0, dec_ready}, 32'd0);
    cyc();
    chk("cap_inflight4", {28'd0, inflight}, 32'd4);
    chk("cap_busy", busy_mask, 32'h1E);
    chk("cap_block_full", {31'd0, dec_ready}, 32'd0);
    drv(1, OP_LOAD, 3'd2, 5'd0, 5'd0, 5'd5, 1, 1, 5'd1, 0, 0);
    cyc();
    chk("cap_after_wb_infl", {28'd0, inflight}, 32'd3);
    chk("cap_after_wb_ready", {31'd0, dec_ready}, 32'd1);
    cyc();
    chk("cap_x5_slot", {26'd0, iss_valid, iss_rd_address}, {26'd0, 1'b1, 5'd5});

    // Flush: discard a slot holding x7 while x2 is in flight.
    do_reset();
    drv(1, OP_OP, 3'd0, 5'd0, 5'd0, 5'd2, 1, 0, 5'd0, 0, 0);
    cyc();
    drv(1, OP_OP, 3'd0, 5'd0, 5'd0, 5'd7, 1, 0, 5'd0, 0, 0);
    cyc();
    drv(1, OP_OP, 3'd0, 5'd0, 5'd0, 5'd8, 1, 0, 5'd0, 1, 0);
    chk("fl_dec_ready", {31'd0, dec_ready}, 32'd0);
    cyc();
    drv(0, OP_OP, 3'd0, 5'd0, 5'd0, 5'd0, 1, 0, 5'd0, 0, 0);
    chk("fl_iss_valid", {31'd0, iss_valid}, 32'd0);
    chk("fl_busy", busy_mask, 32'h4);
    chk("fl_inflight", {28'd0, inflight}, 32'd1);

    // Drain with two ops in flight.
    do_reset();
    drv(1, OP_OP, 3'd0, 5'd0, 5'd0, 5'd10, 1, 0, 5'd0, 0, 0);
    cyc();
    drv(1, OP_OP, 3'd0, 5'd0, 5'd0, 5'd11, 1, 0, 5'd0, 0, 0);
    cyc();
    drv(0, OP_OP, 3'd0, 5'd0, 5'd0, 5'd0, 1, 0, 5'd0, 0, 1);
    cyc();
    chk("dr_inflight2", {28'd0, inflight}, 32'd2);
    chk("dr_ready_off", {31'd0, dec_ready}, 32'd0);
    drv(0, OP_OP, 3'd0, 5'd0, 5'd0, 5'd0, 1, 1, 5'd10, 0, 1);
    cyc();
    chk("dr_done_early1", {31'd0, drain_done}, 32'd0);
    drv(0, OP_OP, 3'd0, 5'd0, 5'd0, 5'd0, 1, 1, 5'd11, 0, 1);
    cyc();
    chk("dr_done_early2", {31'd0, drain_done}, 32'd0);
    chk("dr_inflight0", {28'd0, inflight}, 32'd0);
    drv(0, OP_OP, 3'd0, 5'd0, 5'd0, 5'd0, 1, 0, 5'd0, 0, 1);
    cyc();
    chk("dr_done", {31'd0, drain_done}, 32'd1);
    chk("dr_done_ready", {31'd0, dec_ready}, 32'd0);
    drv(0, OP_OP, 3'd0, 5'd0, 5'd0, 5'd0, 1, 0, 5'd0, 0, 0);
    cyc();
    chk("dr_release_done", {31'd0, drain_done}, 32'd0);
    chk("dr_release_ready", {31'd0, dec_ready}, 32'd1);

    // Early drop of drain_req returns to RUN without reaching DONE.
    drv(0, OP_OP, 3'd0, 5'd0, 5'd0, 5'd0, 1, 0, 5'd0, 0, 1);
    cyc();
    drv(0, OP_OP, 3'd0, 5'd0, 5'd0, 5'd0, 1, 0, 5'd0, 0, 0);
    cyc();
    chk("dr_abort_ready", {31'd0, dec_ready}, 32'd1);
    chk("dr_abort_done", {31'd0, drain_done}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
